alu_result_stage: RTL and testbench
===================================

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001: Parameter WIDTH, default 32, sets the data width of the logic-unit result.
REQ-002: Parameter CNT_W, default 8, sets the width of the accepted-result counter.
REQ-003: clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004: rst  input  1  is the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005: in_valid  input  1  indicates that the upstream logic unit (AND/OR/XOR reduce stage) presents a result.
REQ-006: in_ready  output  1  indicates that the stage can accept a result this cycle.
REQ-007: y  input  WIDTH  is the result word from the logic unit.
REQ-008: op  input  2  is the opcode tag that travels with the result.
REQ-009: out_valid  output  1  indicates that the head entry is valid.
REQ-010: out_ready  input  1  indicates that the downstream consumer takes the head entry.
REQ-011: out_y  output  WIDTH  is the head result word.
REQ-012: out_op  output  2  is the head opcode tag.
REQ-013: out_zero  output  1  is the head zero flag.
REQ-014: out_neg  output  1  is the head sign flag.
REQ-015: out_par  output  1  is the head parity flag (see Configuration).
REQ-016: count  output  2  is the number of occupied entries, 0 to 2.
REQ-017: acc_cnt  output  CNT_W  is the running count of accepted results.

Function
REQ-018: The stage SHALL be a 2-entry, in-order FIFO with states EMPTY, ONE and FULL, encoded by count = 0, 1 and 2.
REQ-019: in_ready SHALL be a decode of state only: high in EMPTY and ONE, low in FULL; it SHALL NOT depend on out_ready.
REQ-020: A push SHALL occur when in_valid and in_ready are both high; a pop SHALL occur when out_valid and out_ready are both high.
REQ-021: State transitions SHALL be:
  - EMPTY, push -> ONE
  - ONE, push only -> FULL
  - ONE, pop only -> EMPTY
  - ONE, push and pop -> ONE, with the new entry becoming head
  - FULL, pop -> ONE
  - any other combination -> hold.
REQ-022: In FULL, a concurrent in_valid SHALL be ignored, with no push and no loss of stored data.
REQ-023: Flags SHALL be computed from y at push time and stored with the entry:
  - zero = 1 when y is all zeros
  - neg = y[WIDTH-1]
  - par = XOR of all bits of y.
REQ-024: Latency SHALL be one cycle: a result pushed in cycle N appears at out_* with out_valid high in cycle N+1 if the FIFO was EMPTY.
REQ-025: out_valid SHALL equal (count != 0).
REQ-026: out_y, out_op and the out flags SHALL show the head entry whenever out_valid is high, and SHALL hold stable while out_valid is high and out_ready is low.
REQ-027: acc_cnt SHALL increment by 1 on every push and wrap modulo 2^CNT_W, so 255 -> 0 when CNT_W = 8.
REQ-028: A pop in EMPTY SHALL have no effect.

Reset
REQ-029: When rst is high at a clock edge, the state SHALL become EMPTY.
REQ-030: When rst is high at a clock edge, count, acc_cnt, out_y, out_op, out_zero, out_neg and out_par SHALL become 0, out_valid SHALL become 0, and in_ready SHALL become 1 in the following cycle.
REQ-031: Reset SHALL take priority over a simultaneous push or pop, and all in-flight entries SHALL be discarded.

Configuration
REQ-032: Macro ALU_RESULT_PARITY_EN defined: out_par SHALL carry the stored parity per REQ-023.
REQ-033: Macro ALU_RESULT_PARITY_EN undefined: no parity storage SHALL be built and out_par SHALL be tied to 0.

Verification
REQ-034: rst = 1 for 2 cycles -> count = 0, out_valid = 0, in_ready = 1, acc_cnt = 0, all out_* = 0.
REQ-035: Push y = 32'h00000000, op = 2'b01, with out_ready = 0 -> next cycle out_valid = 1, out_y = 0, out_zero = 1, out_neg = 0, out_par = 0, count = 1.
REQ-036: Push 32'h80000001 then 32'hFFFFFFFF with out_ready = 0 -> count = 2, in_ready = 0; a third push of 32'h12345678 is ignored; draining yields 80000001 (neg = 1, par = 0), then FFFFFFFF (neg = 1, par = 0), then out_valid = 0.
REQ-037: In ONE, with head 32'h0000000F, push 32'h00000007 and pop in the same cycle -> count stays 1, out_y = 00000007, out_par = 1.
REQ-038: 256 pushes, each popped -> acc_cnt wraps to 0; then assert rst while FULL -> count = 0, out_valid = 0 in the next cycle.
REQ-039: Build without ALU_RESULT_PARITY_EN and push 32'h00000001 -> out_par = 0, all other flags and data unchanged.

Source files
------------

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - 2-entry in-order result FIFO with stored zero/sign/parity flags.
// Optional parity storage enabled by macro ALU_RESULT_PARITY_EN (out_par tied to 0 otherwise).
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] y,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [1:0]       out_op,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_par,
  output logic [1:0]       count,
  output logic [CNT_W-1:0] acc_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;

  logic [WIDTH-1:0] head_y, tail_y;
  logic [1:0]       head_op, tail_op;
  logic             head_zero, head_neg;
  logic             tail_zero, tail_neg;

  logic push, pop;
  logic in_zero, in_neg;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign count     = state;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Flags are captured at push time so the consumer never recomputes them.
  assign in_zero = ~|y;
  assign in_neg  = y[WIDTH-1];

  assign out_y    = head_y;
  assign out_op   = head_op;
  assign out_zero = head_zero;
  assign out_neg  = head_neg;

`ifdef ALU_RESULT_PARITY_EN
  logic head_par, tail_par;
  logic in_par;

  assign in_par  = ^y;
  assign out_par = head_par;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_par <= 1'b0;
      tail_par <= 1'b0;
    end else begin
      case (state)
        EMPTY: if (push) head_par <= in_par;
        ONE: begin
          if (push && !pop) tail_par <= in_par;
          else if (push && pop) head_par <= in_par;
        end
        FULL: if (pop) head_par <= tail_par;
        default: ;
      endcase
    end
  end
`else
  assign out_par = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      acc_cnt   <= '0;
      head_y    <= '0;
      head_op   <= '0;
      head_zero <= 1'b0;
      head_neg  <= 1'b0;
      tail_y    <= '0;
      tail_op   <= '0;
      tail_zero <= 1'b0;
      tail_neg  <= 1'b0;
    end else begin
      if (push) acc_cnt <= acc_cnt + CNT_W'(1);
      case (state)
        EMPTY: begin
          if (push) begin
            head_y    <= y;
            head_op   <= op;
            head_zero <= in_zero;
            head_neg  <= in_neg;
            state     <= ONE;
          end
        end
        ONE: begin
          if (push && !pop) begin
            tail_y    <= y;
            tail_op   <= op;
            tail_zero <= in_zero;
            tail_neg  <= in_neg;
            state     <= FULL;
          end else if (!push && pop) begin
            state <= EMPTY;
          end else if (push && pop) begin
            // Head leaves as the new result arrives, so the newcomer becomes head.
            head_y    <= y;
            head_op   <= op;
            head_zero <= in_zero;
            head_neg  <= in_neg;
          end
        end
        FULL: begin
          if (pop) begin
            head_y    <= tail_y;
            head_op   <= tail_op;
            head_zero <= tail_zero;
            head_neg  <= tail_neg;
            state     <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - scoreboard bench for alu_result_stage (parity expectation follows ALU_RESULT_PARITY_EN).
module tb_alu_result_stage;

`ifdef ALU_RESULT_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] y = '0;
  logic [1:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_y;
  logic [1:0]  out_op;
  logic        out_zero, out_neg, out_par;
  logic [1:0]  count;
  logic [7:0]  acc_cnt;

  alu_result_stage #(.WIDTH(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .y(y), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_op(out_op), .out_zero(out_zero), .out_neg(out_neg), .out_par(out_par),
    .count(count), .acc_cnt(acc_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] y;
    logic [1:0]  op;
    logic        z;
    logic        n;
    logic        p;
  } ent_t;

  ent_t       sb[$];
  logic [7:0] exp_acc = '0;
  int         checks = 0;
  int         errors = 0;

  function automatic ent_t mk(input logic [31:0] v, input logic [1:0] o);
    ent_t e;
    e.y  = v;
    e.op = o;
    e.z  = (v == 32'd0);
    e.n  = v[31];
    e.p  = PAR_EN ? ^v : 1'b0;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    int   n;
    ent_t h;
    n = sb.size();
    check("count", 64'(count), 64'(n));
    check("in_ready", 64'(in_ready), 64'(n < 2));
    check("out_valid", 64'(out_valid), 64'(n != 0));
    check("acc_cnt", 64'(acc_cnt), 64'(exp_acc));
    if (n != 0) begin
      h = sb[0];
      check("out_y", 64'(out_y), 64'(h.y));
      check("out_op", 64'(out_op), 64'(h.op));
      check("out_zero", 64'(out_zero), 64'(h.z));
      check("out_neg", 64'(out_neg), 64'(h.n));
      check("out_par", 64'(out_par), 64'(h.p));
    end
  endtask

  task automatic step(input logic iv, input logic [31:0] iy, input logic [1:0] iop, input logic ordy);
    logic do_push, do_pop;
    ent_t d;
    in_valid  = iv;
    y         = iy;
    op        = iop;
    out_ready = ordy;
    do_push   = iv && (sb.size() < 2);
    do_pop    = ordy && (sb.size() != 0);
    @(posedge clk);
    #1;
    if (do_pop) d = sb.pop_front();
    if (do_push) begin
      sb.push_back(mk(iy, iop));
      exp_acc = exp_acc + 8'd1;
    end
    check_state();
  endtask

  task automatic reset_cycles(input int n);
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    y = 32'hDEADBEEF;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    sb.delete();
    exp_acc = '0;
    check_state();
    check("rst_out_y", 64'(out_y), 64'd0);
    check("rst_out_op", 64'(out_op), 64'd0);
    check("rst_flags", 64'({out_zero, out_neg, out_par}), 64'd0);
  endtask

  initial begin
    // Reset held two cycles with push/pop attempts active.
    reset_cycles(2);

    // Zero result: zero flag set, one-cycle latency.
    step(1'b1, 32'h00000000, 2'b01, 1'b0);
    check("zero_out_valid", 64'(out_valid), 64'd1);
    check("zero_flag", 64'(out_zero), 64'd1);
    check("zero_count", 64'(count), 64'd1);
    step(1'b0, '0, '0, 1'b1);

    // Fill, attempt overflow, hold while stalled, then drain.
    step(1'b1, 32'h80000001, 2'b10, 1'b0);
    step(1'b1, 32'hFFFFFFFF, 2'b11, 1'b0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    step(1'b1, 32'h12345678, 2'b00, 1'b0);
    check("full_hold_y", 64'(out_y), 64'h80000001);
    step(1'b0, '0, '0, 1'b1);
    check("drain2_y", 64'(out_y), 64'hFFFFFFFF);
    check("drain2_neg", 64'(out_neg), 64'd1);
    step(1'b0, '0, '0, 1'b1);
    check("drained", 64'(out_valid), 64'd0);

    // Pop in EMPTY has no effect.
    step(1'b0, '0, '0, 1'b1);

    // Simultaneous push and pop in ONE: newcomer becomes head.
    step(1'b1, 32'h0000000F, 2'b01, 1'b0);
    step(1'b1, 32'h00000007, 2'b10, 1'b1);
    check("pp_count", 64'(count), 64'd1);
    check("pp_y", 64'(out_y), 64'h00000007);
    check("pp_par", 64'(out_par), 64'(PAR_EN));
    step(1'b0, '0, '0, 1'b1);

    // Parity of a single set bit.
    step(1'b1, 32'h00000001, 2'b00, 1'b0);
    check("one_par", 64'(out_par), 64'(PAR_EN));
    check("one_flags", 64'({out_zero, out_neg}), 64'd0);
    step(1'b0, '0, '0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    // 256 accepted results from reset wrap the counter to zero.
    reset_cycles(1);
    for (int i = 0; i < 256; i++)
      step(1'b1, 32'(i * 32'h01010101), 2'(i), 1'b1);
    check("acc_wrap", 64'(acc_cnt), 64'd0);
    step(1'b0, '0, '0, 1'b1);

    // Reset while FULL discards everything.
    step(1'b1, 32'hA5A5A5A5, 2'b01, 1'b0);
    step(1'b1, 32'h5A5A5A5A, 2'b10, 1'b0);
    check("pre_rst_count", 64'(count), 64'd2);
    reset_cycles(1);
    check("post_rst_count", 64'(count), 64'd0);
    check("post_rst_valid", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
